// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for if_id_buffer.
// The master side is fetch/decode/EX; the slave side is the buffer itself.
interface if_id_buffer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ins;
  logic [31:0]      in_pc4;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_ins;
  logic [31:0]      out_pc4;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output in_valid, in_ins, in_pc4, flush, out_ready,
    input  in_ready, out_valid, out_ins, out_pc4, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_ins, in_pc4, flush, out_ready,
    output in_ready, out_valid, out_ins, out_pc4, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_buffer.sv
// Elastic IF/ID FIFO with valid/ready on both sides and flush on taken branch.
// Define IFID_PERF_EN to build the saturating stall/flush performance counters.
module if_id_buffer #(
  parameter int unsigned DEPTH   = 2,
  parameter logic [31:0] NOP_INS = 32'h0,
  parameter int unsigned CNT_W   = 32
) (
  input logic           CLK,
  input logic           RST,
  if_id_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [63:0]       mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CW-1:0]     count;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;

  assign in_ready  = !RST && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready && !bus.flush;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_ins   = out_valid ? mem[rd_ptr][63:32] : NOP_INS;
  assign bus.out_pc4   = out_valid ? mem[rd_ptr][31:0]  : 32'h0;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_ins, bus.in_pc4};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef IFID_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (bus.in_valid && !in_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (bus.flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
  assign bus.flush_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios then random traffic
// against a queue-based reference model. Honours IFID_PERF_EN like the design.
module tb_if_id_buffer;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] q[$];
  longint unsigned stall_m = 0;
  longint unsigned flush_m = 0;

  if_id_buffer_if #(.CNT_W(32)) bus ();

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INS(NOP), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] h;
    h = (q.size() != 0) ? q[0] : {NOP, 32'h0};
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(!RST && (q.size() < DEPTH)));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
    chk({tag, ".out_ins"},   64'(bus.out_ins),   64'(h[63:32]));
    chk({tag, ".out_pc4"},   64'(bus.out_pc4),   64'(h[31:0]));
`ifdef IFID_PERF_EN
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), stall_m);
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), flush_m);
`else
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'd0);
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'd0);
`endif
  endtask

  // Called at a negedge: drive, check pre-edge outputs, clock, update model.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc4, input logic fl, input logic rdy,
                      output logic accepted);
    logic rdy_m, push, pop;
    bus.in_valid  = v;
    bus.in_ins    = ins;
    bus.in_pc4    = pc4;
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    check_all(tag);
    rdy_m = !RST && (q.size() < DEPTH);
    push  = v && rdy_m && !fl;
    pop   = (q.size() != 0) && rdy && !fl;
    if (v && !rdy_m) stall_m++;
    if (fl) flush_m++;
    @(posedge CLK);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({ins, pc4});
    end
    accepted = push;
    @(negedge CLK);
  endtask

  initial begin
    logic acc;
    logic [31:0] ins, pc4;
    logic pending;
    int sent;

    bus.in_valid = 1'b0; bus.in_ins = '0; bus.in_pc4 = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #1;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("release.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge CLK);

    // Passthrough
    step("pass0", 1'b1, 32'h20110100, 32'h4, 1'b0, 1'b1, acc);
    step("pass1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    step("pass2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Fill and stall, then drain in order
    step("fillA", 1'b1, 32'hAAAA0001, 32'h100, 1'b0, 1'b0, acc);
    step("fillB", 1'b1, 32'hBBBB0002, 32'h104, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) step("stallC", 1'b1, 32'hCCCC0003, 32'h108, 1'b0, 1'b0, acc);
`ifdef IFID_PERF_EN
    chk("stall3", 64'(bus.stall_cnt), 64'd3);
`endif
    pending = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("drain", pending, 32'hCCCC0003, 32'h108, 1'b0, 1'b1, acc);
      if (acc) pending = 1'b0;
    end

    // Simultaneous push/pop at count 1
    step("simA", 1'b1, 32'h11110001, 32'h200, 1'b0, 1'b0, acc);
    step("simB", 1'b1, 32'h22220002, 32'h204, 1'b0, 1'b1, acc);
    step("simChk", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    chk("sim.out_ins", 64'(bus.out_ins), 64'h22220002);
    step("simDrain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Flush with same-cycle push and pop attempts
    step("flA", 1'b1, 32'h33330001, 32'h300, 1'b0, 1'b0, acc);
    step("flB", 1'b1, 32'h33330002, 32'h304, 1'b0, 1'b0, acc);
    step("flush", 1'b1, 32'h44440003, 32'h308, 1'b1, 1'b1, acc);
    chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush.out_ins", 64'(bus.out_ins), 64'(NOP));
    step("postflush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Stream 10 words across pointer wrap with toggling out_ready
    sent = 0;
    for (int c = 0; c < 60 && (sent < 10 || q.size() != 0); c++) begin
      step("wrap", sent < 10, 32'h5000_0000 + 32'(sent), 32'(sent * 4 + 4), 1'b0, c[0], acc);
      if (acc) sent++;
    end
    chk("wrap.sent", 64'(sent), 64'd10);
    chk("wrap.empty", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-stream at count 2
    step("rsA", 1'b1, 32'h66660001, 32'h600, 1'b0, 1'b0, acc);
    step("rsB", 1'b1, 32'h66660002, 32'h604, 1'b0, 1'b0, acc);
    #2;
    RST = 1'b1;
    #1;
    q.delete(); stall_m = 0; flush_m = 0;
    bus.in_valid = 1'b0;
    check_all("midreset");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_all("afterreset");

    // Random traffic obeying the hold-while-stalled rule
    pending = 1'b0; ins = '0; pc4 = '0;
    for (int c = 0; c < 300; c++) begin
      logic v;
      if (!pending) begin
        v   = ($urandom_range(0, 3) != 0);
        ins = $urandom;
        pc4 = $urandom;
      end else v = 1'b1;
      step("rand", v, ins, pc4, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, acc);
      pending = v && !acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
